// File: rtl/mp64_pkg.sv
// Shared encodings, FSM state type and small byte-lane helpers for the MP64
// memory target and its BRAM.
package mp64_pkg;

  localparam logic [1:0]  MP64_SZ_BYTE   = 2'd0;
  localparam logic [1:0]  MP64_SZ_HALF   = 2'd1;
  localparam logic [1:0]  MP64_SZ_WORD   = 2'd2;
  localparam logic [1:0]  MP64_SZ_DWORD  = 2'd3;
  localparam logic [63:0] MP64_ERR_RDATA = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    INT_ACC,
    INT_DATA,
    EXT_WAIT,
    ACK
  } mp64_state_e;

  function automatic logic [7:0] mp64_size_be(input logic [1:0] size);
    case (size)
      MP64_SZ_BYTE: return 8'h01;
      MP64_SZ_HALF: return 8'h03;
      MP64_SZ_WORD: return 8'h0F;
      default:      return 8'hFF;
    endcase
  endfunction

  function automatic logic mp64_misaligned(input logic [2:0] lsb, input logic [1:0] size);
    case (size)
      MP64_SZ_BYTE: return 1'b0;
      MP64_SZ_HALF: return lsb[0];
      MP64_SZ_WORD: return |lsb[1:0];
      default:      return |lsb;
    endcase
  endfunction

  function automatic logic [63:0] mp64_be_to_mask(input logic [7:0] be);
    logic [63:0] mask;
    for (int b = 0; b < 8; b++) mask[8*b +: 8] = {8{be[b]}};
    return mask;
  endfunction

endpackage

// File: rtl/mp64_bram64.sv
// Single-port 64-bit BRAM with per-byte write enables and a registered
// (one-cycle) read port. Contents are never reset.
module mp64_bram64 #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [7:0]        be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [63:0]       wdata_i,
  output logic [63:0]       rdata_o
);

  logic [63:0] mem_q [2**ADDR_W];
  logic [63:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 8; b++) begin
          if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mp64_mem_target.sv
// MP64 memory target: serves the low address window from an internal BRAM and
// forwards everything else to an external port with an ack timeout.
module mp64_mem_target
  import mp64_pkg::*;
#(
  parameter int          MEM_WORDS_LOG2 = 14,
  parameter logic [15:0] EXT_TIMEOUT    = 16'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req,
  input  logic [63:0] mem_addr,
  input  logic [63:0] mem_wdata,
  input  logic        mem_wen,
  input  logic [1:0]  mem_size,
  output logic [63:0] mem_rdata,
  output logic        mem_ack,
  output logic        ext_req,
  output logic [63:0] ext_addr,
  output logic [63:0] ext_wdata,
  output logic        ext_wen,
  output logic [1:0]  ext_size,
  input  logic [63:0] ext_rdata,
  input  logic        ext_ack,
  output logic        bus_err,
  output logic [63:0] err_addr
);

  mp64_state_e state_q, state_d;
  logic [63:0] addr_q, wdata_q;
  logic        wen_q;
  logic [1:0]  size_q;
  logic [63:0] rdata_q, rdata_d, ext_addr_q, ext_addr_d, ext_wdata_q, ext_wdata_d;
  logic [63:0] err_addr_q, err_addr_d;
  logic        ack_q, ack_d, ext_req_q, ext_req_d, ext_wen_q, ext_wen_d, err_q, err_d;
  logic [1:0]  ext_size_q, ext_size_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic        accept, is_int;
  logic [7:0]  bram_be;
  logic [63:0] bram_wdata, bram_rdata, rd_lane;

  assign accept  = (state_q == IDLE) && mem_req && !ack_q;
  assign is_int  = (mem_addr[63:3] >> MEM_WORDS_LOG2) == 61'd0;
  assign cnt_inc = cnt_q + 16'd1;

  // Byte-lane steering between the right-justified bus and the BRAM word
  assign bram_be    = mp64_size_be(size_q) << addr_q[2:0];
  assign bram_wdata = wdata_q << {addr_q[2:0], 3'b000};
  assign rd_lane    = (bram_rdata >> {addr_q[2:0], 3'b000}) &
                      mp64_be_to_mask(mp64_size_be(size_q));

  mp64_bram64 #(.ADDR_W(MEM_WORDS_LOG2)) u_bram (
    .clk     (clk),
    .en_i    (state_q == INT_ACC),
    .we_i    (wen_q),
    .be_i    (bram_be),
    .addr_i  (addr_q[3 +: MEM_WORDS_LOG2]),
    .wdata_i (bram_wdata),
    .rdata_o (bram_rdata)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      wen_q   <= mem_wen;
      size_q  <= mem_size;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      ext_req_q   <= 1'b0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
      ext_wen_q   <= 1'b0;
      ext_size_q  <= '0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      ext_req_q   <= ext_req_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
      ext_wen_q   <= ext_wen_d;
      ext_size_q  <= ext_size_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    ext_req_d   = ext_req_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    ext_wen_d   = ext_wen_q;
    ext_size_d  = ext_size_q;
    err_addr_d  = err_addr_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (mp64_misaligned(mem_addr[2:0], mem_size)) begin
            state_d    = ACK;
            ack_d      = 1'b1;
            rdata_d    = '0;
            err_d      = 1'b1;
            err_addr_d = mem_addr;
          end else if (is_int) begin
            state_d = INT_ACC;
          end else begin
            state_d     = EXT_WAIT;
            ext_req_d   = 1'b1;
            ext_addr_d  = mem_addr;
            ext_wdata_d = mem_wdata;
            ext_wen_d   = mem_wen;
            ext_size_d  = mem_size;
            cnt_d       = '0;
          end
        end
      end
      INT_ACC: state_d = INT_DATA;
      INT_DATA: begin
        state_d = ACK;
        ack_d   = 1'b1;
        rdata_d = wen_q ? 64'd0 : rd_lane;
      end
      EXT_WAIT: begin
        cnt_d = cnt_inc;
        // An ack arriving on the timeout cycle still wins
        if (ext_ack) begin
          state_d   = ACK;
          ack_d     = 1'b1;
          rdata_d   = ext_rdata;
          ext_req_d = 1'b0;
        end else if (cnt_inc == EXT_TIMEOUT) begin
          state_d    = ACK;
          ack_d      = 1'b1;
          rdata_d    = MP64_ERR_RDATA;
          err_d      = 1'b1;
          err_addr_d = addr_q;
          ext_req_d  = 1'b0;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_rdata = rdata_q;
  assign mem_ack   = ack_q;
  assign ext_req   = ext_req_q;
  assign ext_addr  = ext_addr_q;
  assign ext_wdata = ext_wdata_q;
  assign ext_wen   = ext_wen_q;
  assign ext_size  = ext_size_q;
  assign bus_err   = err_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_mp64_mem_target.sv
// Self-checking bench for mp64_mem_target: directed scenarios plus randomized
// internal traffic against a byte-array memory model.
module tb_mp64_mem_target;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_wen;
  logic [1:0]  mem_size;
  logic [63:0] mem_rdata;
  logic        mem_ack;
  logic        ext_req;
  logic [63:0] ext_addr, ext_wdata;
  logic        ext_wen;
  logic [1:0]  ext_size;
  logic [63:0] ext_rdata;
  logic        ext_ack;
  logic        bus_err;
  logic [63:0] err_addr;

  int ntot = 0;
  int nbad = 0;

  // external responder state
  int          ext_delay = -1;
  logic [63:0] ext_data_v = '0;
  logic        resp_ack = 1'b0;
  logic        late_ack = 1'b0;
  int          hi_cnt = 0;
  int          run = 0;
  logic [63:0] seen_addr, seen_wdata;
  logic        seen_wen;
  logic [1:0]  seen_size;

  logic [7:0] mem_b [0:1023];

  assign ext_ack   = resp_ack | late_ack;
  assign ext_rdata = ext_data_v;

  always #5 clk = ~clk;

  mp64_mem_target #(.MEM_WORDS_LOG2(14), .EXT_TIMEOUT(16'd1024)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_size(mem_size),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ext_req(ext_req),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_wen(ext_wen),
    .ext_size(ext_size), .ext_rdata(ext_rdata), .ext_ack(ext_ack),
    .bus_err(bus_err), .err_addr(err_addr)
  );

  initial begin
    forever begin
      @(negedge clk);
      if (ext_req) begin
        run++;
        hi_cnt++;
        if (run == 1) begin
          seen_addr  = ext_addr;
          seen_wdata = ext_wdata;
          seen_wen   = ext_wen;
          seen_size  = ext_size;
        end
        resp_ack = (run == ext_delay);
      end else begin
        run      = 0;
        resp_ack = 1'b0;
      end
    end
  end

  function automatic logic [63:0] model_read(input int a, input logic [1:0] sz);
    logic [63:0] v = '0;
    for (int i = 0; i < (1 << sz); i++) v[8*i +: 8] = mem_b[a + i];
    return v;
  endfunction

  function automatic void model_write(input int a, input logic [1:0] sz, input logic [63:0] d);
    for (int i = 0; i < (1 << sz); i++) mem_b[a + i] = d[8*i +: 8];
  endfunction

  task automatic do_txn(input logic [63:0] a, input logic [63:0] wd, input logic we,
                        input logic [1:0] sz, output logic [63:0] rd, output logic er,
                        output logic [63:0] ea, output int lat);
    @(negedge clk);
    mem_addr = a; mem_wdata = wd; mem_wen = we; mem_size = sz; mem_req = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!mem_ack && lat < 3000);
    mem_req = 1'b0;
    rd = mem_rdata; er = bus_err; ea = err_addr;
    ntot++;
    if (mem_ack !== 1'b1) begin
      nbad++;
      $display("FAIL ack_wait addr=%h: no mem_ack within %0d cycles", a, lat);
    end
    @(posedge clk); #1;
    ntot++;
    if (mem_ack !== 1'b0 || bus_err !== 1'b0 || mem_rdata !== rd) begin
      nbad++;
      $display("FAIL ack_pulse addr=%h: ack=%b err=%b rdata=%h, want 0 0 %h",
               a, mem_ack, bus_err, mem_rdata, rd);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mem_req = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wen = 1'b0; mem_size = '0;
    repeat (3) @(posedge clk);
    #1;
    ntot++;
    if ({mem_ack, ext_req, ext_wen, bus_err} !== 4'b0) begin
      nbad++; $display("FAIL reset_ctrl: ack/ext_req/ext_wen/err=%b want 0000",
                       {mem_ack, ext_req, ext_wen, bus_err});
    end
    ntot++;
    if (mem_rdata !== 64'd0) begin nbad++; $display("FAIL reset_rdata: got %h want 0", mem_rdata); end
    ntot++;
    if (ext_addr !== 64'd0 || ext_wdata !== 64'd0 || ext_size !== 2'd0) begin
      nbad++; $display("FAIL reset_ext: addr=%h wdata=%h size=%0d want 0", ext_addr, ext_wdata, ext_size);
    end
    ntot++;
    if (err_addr !== 64'd0) begin nbad++; $display("FAIL reset_err_addr: got %h want 0", err_addr); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_fill_and_dword;
    logic [63:0] rd, ea, d; logic er; int lat;
    for (int w = 0; w < 128; w++) begin
      d = {$urandom, $urandom};
      do_txn(64'(w * 8), d, 1'b1, 2'd3, rd, er, ea, lat);
      model_write(w * 8, 2'd3, d);
    end
    do_txn(64'h100, 64'h1122334455667788, 1'b1, 2'd3, rd, er, ea, lat);
    model_write(32'h100, 2'd3, 64'h1122334455667788);
    do_txn(64'h100, 64'h0, 1'b0, 2'd3, rd, er, ea, lat);
    ntot++;
    if (lat !== 3) begin nbad++; $display("FAIL dword_latency: got %0d want 3", lat); end
    ntot++;
    if (rd !== 64'h1122334455667788 || er !== 1'b0) begin
      nbad++; $display("FAIL dword_read: got %h err=%b want 1122334455667788 err=0", rd, er);
    end
  endtask

  task automatic test_byte_lanes;
    logic [63:0] rd, ea; logic er; int lat;
    do_txn(64'h103, 64'hFFFF_FFFF_FFFF_FFAB, 1'b1, 2'd0, rd, er, ea, lat);
    model_write(32'h103, 2'd0, 64'hAB);
    do_txn(64'h100, 64'h0, 1'b0, 2'd3, rd, er, ea, lat);
    ntot++;
    if (rd !== 64'h11223344AB667788) begin
      nbad++; $display("FAIL byte_merge: got %h want 11223344ab667788", rd);
    end
    do_txn(64'h102, 64'h0, 1'b0, 2'd1, rd, er, ea, lat);
    ntot++;
    if (rd !== 64'h000000000000AB66) begin
      nbad++; $display("FAIL half_read: got %h want 000000000000ab66", rd);
    end
  endtask

  task automatic test_misaligned;
    logic [63:0] rd, ea; logic er; int lat;
    do_txn(64'h102, 64'h0, 1'b0, 2'd2, rd, er, ea, lat);
    ntot++;
    if (er !== 1'b1 || ea !== 64'h102 || rd !== 64'd0 || lat !== 1) begin
      nbad++; $display("FAIL misaligned_read: err=%b addr=%h rdata=%h lat=%0d want 1 102 0 1", er, ea, rd, lat);
    end
    do_txn(64'h101, 64'hBEEF, 1'b1, 2'd1, rd, er, ea, lat);
    ntot++;
    if (er !== 1'b1 || ea !== 64'h101) begin
      nbad++; $display("FAIL misaligned_write: err=%b addr=%h want 1 101", er, ea);
    end
    do_txn(64'h100, 64'h0, 1'b0, 2'd3, rd, er, ea, lat);
    ntot++;
    if (rd !== 64'h11223344AB667788 || er !== 1'b0) begin
      nbad++; $display("FAIL misaligned_nowrite: got %h want 11223344ab667788", rd);
    end
  endtask

  task automatic test_random;
    logic [63:0] rd, ea, d, exp; logic er, we, mis; int lat, a; logic [1:0] sz;
    for (int n = 0; n < 250; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom_range(0, 1016);
      if ($urandom_range(0, 4) != 0) a = a & ~((1 << sz) - 1);
      we = 1'($urandom_range(0, 1));
      d  = {$urandom, $urandom};
      mis = (a % (1 << sz)) != 0;
      exp = mis ? 64'd0 : model_read(a, sz);
      do_txn(64'(a), d, we, sz, rd, er, ea, lat);
      ntot++;
      if (er !== mis || lat !== (mis ? 1 : 3) || (mis && ea !== 64'(a))) begin
        nbad++; $display("FAIL rand_status a=%h sz=%0d: err=%b lat=%0d ea=%h want err=%b", a, sz, er, lat, ea, mis);
      end
      if (!we || mis) begin
        ntot++;
        if (rd !== exp) begin
          nbad++; $display("FAIL rand_rdata a=%h sz=%0d: got %h want %h", a, sz, rd, exp);
        end
      end
      if (we && !mis) model_write(a, sz, d);
    end
  endtask

  task automatic test_boundary;
    logic [63:0] rd, ea, d; logic er; int lat, h0;
    d = {$urandom, $urandom};
    do_txn(64'h1FFF8, d, 1'b1, 2'd3, rd, er, ea, lat);
    do_txn(64'h1FFF8, 64'h0, 1'b0, 2'd3, rd, er, ea, lat);
    ntot++;
    if (rd !== d || lat !== 3) begin
      nbad++; $display("FAIL last_int_word: got %h lat=%0d want %h lat=3", rd, lat, d);
    end
    ext_delay = 2; ext_data_v = 64'hCAFEBABE12345678; h0 = hi_cnt;
    do_txn(64'h20000, 64'h0, 1'b0, 2'd0, rd, er, ea, lat);
    ntot++;
    if (hi_cnt - h0 !== 2 || rd !== 64'hCAFEBABE12345678 || er !== 1'b0) begin
      nbad++; $display("FAIL first_ext_addr: ext_req cycles=%0d rdata=%h err=%b want 2 cafebabe12345678 0",
                       hi_cnt - h0, rd, er);
    end
  endtask

  task automatic test_ext;
    logic [63:0] rd, ea, d; logic er; int lat, h0;
    ext_delay = 5; ext_data_v = 64'hDEAD; h0 = hi_cnt;
    do_txn(64'h8000_0000, 64'h0, 1'b0, 2'd3, rd, er, ea, lat);
    ntot++;
    if (hi_cnt - h0 !== 5) begin nbad++; $display("FAIL ext_req_len: got %0d want 5", hi_cnt - h0); end
    ntot++;
    if (rd !== 64'hDEAD || er !== 1'b0 || seen_addr !== 64'h8000_0000 || seen_wen !== 1'b0) begin
      nbad++; $display("FAIL ext_read: rdata=%h err=%b addr=%h wen=%b want dead 0 80000000 0",
                       rd, er, seen_addr, seen_wen);
    end
    d = {$urandom, $urandom};
    ext_delay = $urandom_range(1, 9);
    do_txn(64'h4000_0008, d, 1'b1, 2'd3, rd, er, ea, lat);
    ntot++;
    if (seen_addr !== 64'h4000_0008 || seen_wdata !== d || seen_wen !== 1'b1 ||
        seen_size !== 2'd3 || lat !== ext_delay + 1) begin
      nbad++; $display("FAIL ext_write: addr=%h wdata=%h wen=%b size=%0d lat=%0d want %h wen=1 size=3 lat=%0d",
                       seen_addr, seen_wdata, seen_wen, seen_size, lat, d, ext_delay + 1);
    end
  endtask

  task automatic test_ext_timeout;
    logic [63:0] rd, ea; logic er; int lat, h0, acks;
    ext_delay = -1; h0 = hi_cnt;
    do_txn(64'h9000_0010, 64'h0, 1'b0, 2'd3, rd, er, ea, lat);
    ntot++;
    if (hi_cnt - h0 !== 1024 || lat !== 1025) begin
      nbad++; $display("FAIL timeout_len: ext_req cycles=%0d lat=%0d want 1024 1025", hi_cnt - h0, lat);
    end
    ntot++;
    if (rd !== 64'hFFFF_FFFF_FFFF_FFFF || er !== 1'b1 || ea !== 64'h9000_0010) begin
      nbad++; $display("FAIL timeout_err: rdata=%h err=%b addr=%h want ffffffffffffffff 1 90000010", rd, er, ea);
    end
    acks = 0;
    @(negedge clk); late_ack = 1'b1;
    repeat (4) begin @(posedge clk); #1; if (mem_ack || ext_req) acks++; end
    late_ack = 1'b0;
    ntot++;
    if (acks !== 0) begin nbad++; $display("FAIL late_ack: %0d spurious cycles, want 0", acks); end
  endtask

  task automatic test_reset_in_ext;
    logic [63:0] rd, ea; logic er; int lat, acks;
    ext_delay = -1;
    @(negedge clk);
    mem_addr = 64'h8000_0100; mem_wen = 1'b0; mem_size = 2'd3; mem_req = 1'b1;
    repeat (3) @(negedge clk);
    ntot++;
    if (ext_req !== 1'b1) begin nbad++; $display("FAIL rst_ext_pre: ext_req=%b want 1", ext_req); end
    rst_n = 1'b0; mem_req = 1'b0;
    @(posedge clk); #1;
    ntot++;
    if (ext_req !== 1'b0 || mem_ack !== 1'b0) begin
      nbad++; $display("FAIL rst_ext_abort: ext_req=%b ack=%b want 0 0", ext_req, mem_ack);
    end
    acks = 0;
    repeat (2) begin @(posedge clk); #1; if (mem_ack) acks++; end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; if (mem_ack) acks++; end
    ntot++;
    if (acks !== 0) begin nbad++; $display("FAIL rst_no_ack: %0d acks, want 0", acks); end
    do_txn(64'h100, 64'h0, 1'b0, 2'd3, rd, er, ea, lat);
    ntot++;
    if (rd !== model_read(32'h100, 2'd3) || er !== 1'b0 || lat !== 3) begin
      nbad++; $display("FAIL rst_recover: got %h lat=%0d want %h lat=3", rd, lat, model_read(32'h100, 2'd3));
    end
  endtask

  initial begin
    test_reset();
    test_fill_and_dword();
    test_byte_lanes();
    test_misaligned();
    test_random();
    test_boundary();
    test_ext();
    test_ext_timeout();
    test_reset_in_ext();
    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule
